// File: rtl/mips_pkg.sv
// Shared MIPS constants for the write-back stage: widths, opcode/funct codes
// and the load/write-data selector types.
package mips_pkg;

  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned NREG = 32;

  localparam logic [AW-1:0] REG_RA = 5'd31;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2a;
  localparam logic [5:0] FN_SLTU  = 6'h2b;

  typedef enum logic [2:0] {
    LdWord,
    LdByte,
    LdByteU,
    LdHalf,
    LdHalfU
  } ld_type_e;

  typedef enum logic [1:0] {
    SelAlo,
    SelMem,
    SelLink
  } wd_sel_e;

endpackage

// File: rtl/wb_ldext.sv
// Combinational load extender: picks the addressed byte/half of the aligned
// DM word and sign- or zero-extends it to 32 bits.
module wb_ldext
  import mips_pkg::*;
(
  input  logic [DW-1:0] dmd_i,
  input  logic [1:0]    addr_lo_i,
  input  ld_type_e      ld_type_i,
  output logic [DW-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    unique case (addr_lo_i)
      2'd0:    byte_sel = dmd_i[7:0];
      2'd1:    byte_sel = dmd_i[15:8];
      2'd2:    byte_sel = dmd_i[23:16];
      default: byte_sel = dmd_i[31:24];
    endcase
  end

  // Misaligned half loads ignore addr bit 0 rather than trapping.
  assign half_sel = addr_lo_i[1] ? dmd_i[31:16] : dmd_i[15:0];

  always_comb begin
    unique case (ld_type_i)
      LdByte:  data_o = {{24{byte_sel[7]}}, byte_sel};
      LdByteU: data_o = {24'h0, byte_sel};
      LdHalf:  data_o = {{16{half_sel[15]}}, half_sel};
      LdHalfU: data_o = {16'h0, half_sel};
      default: data_o = dmd_i;
    endcase
  end

endmodule

// File: rtl/wb_grf.sv
// W-stage write-back decode plus the 32x32 GRF with write-through read bypass.
// Optional WB_GRF_TRACE_EN macro enables a simulation-only write trace.
module wb_grf
  import mips_pkg::*;
(
  input  logic          wb_grf_clk_W_i,
  input  logic          wb_grf_rst_W_i,
  input  logic [31:0]   wb_grf_str_W_i,
  input  logic [31:0]   wb_grf_pc4_W_i,
  input  logic [31:0]   wb_grf_alo_W_i,
  input  logic [31:0]   wb_grf_dmd_W_i,
  input  logic [AW-1:0] wb_grf_ra1_D_i,
  input  logic [AW-1:0] wb_grf_ra2_D_i,
  output logic [DW-1:0] wb_grf_rd1_D_o,
  output logic [DW-1:0] wb_grf_rd2_D_o,
  output logic          wb_grf_we_W_o,
  output logic [AW-1:0] wb_grf_wa_W_o,
  output logic [DW-1:0] wb_grf_wd_W_o
);

  logic [5:0]    op, fn;
  logic [AW-1:0] rt, rd;
  logic [4:0]    unused_rs_shamt;

  assign op = wb_grf_str_W_i[31:26];
  assign fn = wb_grf_str_W_i[5:0];
  assign rt = wb_grf_str_W_i[20:16];
  assign rd = wb_grf_str_W_i[15:11];
  assign unused_rs_shamt = wb_grf_str_W_i[25:21] ^ wb_grf_str_W_i[10:6];

  logic          wr;
  logic [AW-1:0] wa;
  wd_sel_e       sel;
  ld_type_e      ld;

  always_comb begin
    wr  = 1'b0;
    wa  = rt;
    sel = SelAlo;
    ld  = LdWord;
    case (op)
      OP_RTYPE: begin
        wa = rd;
        case (fn)
          FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
          FN_XOR, FN_NOR, FN_SLT, FN_SLTU: wr = 1'b1;
          FN_JALR: begin
            wr  = 1'b1;
            sel = SelLink;
          end
          default: wr = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: wr = 1'b1;
      OP_LW:  begin wr = 1'b1; sel = SelMem; ld = LdWord;  end
      OP_LB:  begin wr = 1'b1; sel = SelMem; ld = LdByte;  end
      OP_LBU: begin wr = 1'b1; sel = SelMem; ld = LdByteU; end
      OP_LH:  begin wr = 1'b1; sel = SelMem; ld = LdHalf;  end
      OP_LHU: begin wr = 1'b1; sel = SelMem; ld = LdHalfU; end
      OP_JAL: begin
        wr  = 1'b1;
        wa  = REG_RA;
        sel = SelLink;
      end
      default: wr = 1'b0;
    endcase
  end

  logic [DW-1:0] ld_data;

  wb_ldext u_ldext (
    .dmd_i     (wb_grf_dmd_W_i),
    .addr_lo_i (wb_grf_alo_W_i[1:0]),
    .ld_type_i (ld),
    .data_o    (ld_data)
  );

  logic [DW-1:0] wd;
  logic          we;

  always_comb begin
    unique case (sel)
      SelMem:  wd = ld_data;
      SelLink: wd = wb_grf_pc4_W_i + 32'd4;
      default: wd = wb_grf_alo_W_i;
    endcase
  end

  assign we            = wr && (wa != '0);
  assign wb_grf_we_W_o = we;
  assign wb_grf_wa_W_o = wa;
  assign wb_grf_wd_W_o = wd;

  logic [DW-1:0] regs_q [NREG];

  always_ff @(posedge wb_grf_clk_W_i) begin
    if (wb_grf_rst_W_i) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we) begin
      regs_q[wa] <= wd;
    end
  end

  // $0 is forced to zero here so a corrupted entry can never leak out.
  always_comb begin
    if (wb_grf_ra1_D_i == '0) begin
      wb_grf_rd1_D_o = '0;
    end else if (we && (wa == wb_grf_ra1_D_i)) begin
      wb_grf_rd1_D_o = wd;
    end else begin
      wb_grf_rd1_D_o = regs_q[wb_grf_ra1_D_i];
    end
  end

  always_comb begin
    if (wb_grf_ra2_D_i == '0) begin
      wb_grf_rd2_D_o = '0;
    end else if (we && (wa == wb_grf_ra2_D_i)) begin
      wb_grf_rd2_D_o = wd;
    end else begin
      wb_grf_rd2_D_o = regs_q[wb_grf_ra2_D_i];
    end
  end

`ifdef WB_GRF_TRACE_EN
  always_ff @(posedge wb_grf_clk_W_i) begin
    if (we && !wb_grf_rst_W_i) begin
      $display("@%h: $%d <= %h", wb_grf_pc4_W_i - 32'd4, wa, wd);
    end
  end
`endif

endmodule

// File: tb/tb_wb_grf.sv
// Self-checking bench for wb_grf: directed scenarios plus randomized
// instruction streams checked against a register-array reference model.
module tb_wb_grf;

  logic        clk, rst;
  logic [31:0] str, pc4, alo, dmd;
  logic [4:0]  ra1, ra2;
  logic [31:0] rd1, rd2, wd;
  logic        we;
  logic [4:0]  wa;

  int total = 0;
  int bad   = 0;

  logic [31:0] model [32];

  wb_grf dut (
    .wb_grf_clk_W_i (clk),
    .wb_grf_rst_W_i (rst),
    .wb_grf_str_W_i (str),
    .wb_grf_pc4_W_i (pc4),
    .wb_grf_alo_W_i (alo),
    .wb_grf_dmd_W_i (dmd),
    .wb_grf_ra1_D_i (ra1),
    .wb_grf_ra2_D_i (ra2),
    .wb_grf_rd1_D_o (rd1),
    .wb_grf_rd2_D_o (rd2),
    .wb_grf_we_W_o  (we),
    .wb_grf_wa_W_o  (wa),
    .wb_grf_wd_W_o  (wd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Reference: what the W stage should write, from the ISA definition.
  function automatic void ref_wb(input logic [31:0] s, input logic [31:0] p,
                                 input logic [31:0] a, input logic [31:0] m,
                                 output logic ewe, output logic [4:0] ewa,
                                 output logic [31:0] ewd);
    logic [5:0]  op;
    logic [5:0]  fn;
    int unsigned b;
    bit          w;
    op  = s[31:26];
    fn  = s[5:0];
    w   = 1'b0;
    ewa = 5'd0;
    ewd = 32'd0;
    case (op)
      6'h00: begin
        if (fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21,
                       6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b}) begin
          w = 1'b1; ewa = s[15:11]; ewd = a;
        end else if (fn == 6'h09) begin
          w = 1'b1; ewa = s[15:11]; ewd = p + 32'd4;
        end
      end
      6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f: begin
        w = 1'b1; ewa = s[20:16]; ewd = a;
      end
      6'h23: begin w = 1'b1; ewa = s[20:16]; ewd = m; end
      6'h20, 6'h24: begin
        b = (m >> (8 * int'(a[1:0]))) & 32'hFF;
        if (op == 6'h20 && b >= 128) b = b - 256;
        w = 1'b1; ewa = s[20:16]; ewd = b;
      end
      6'h21, 6'h25: begin
        b = (m >> (16 * int'(a[1]))) & 32'hFFFF;
        if (op == 6'h21 && b >= 32768) b = b - 65536;
        w = 1'b1; ewa = s[20:16]; ewd = b;
      end
      6'h03: begin w = 1'b1; ewa = 5'd31; ewd = p + 32'd4; end
      default: w = 1'b0;
    endcase
    ewe = w && (ewa != 5'd0);
  endfunction

  // Advance one clock edge, mirroring the architectural effect in the model.
  task automatic cycle();
    logic        ewe;
    logic [4:0]  ewa;
    logic [31:0] ewd;
    ref_wb(str, pc4, alo, dmd, ewe, ewa, ewd);
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
    end else if (ewe) begin
      model[ewa] = ewd;
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic [31:0] s, input logic [31:0] p,
                       input logic [31:0] a, input logic [31:0] m);
    str = s; pc4 = p; alo = a; dmd = m;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(32'd0, 32'd0, 32'd0, 32'd0);
    cycle();
    cycle();
    rst = 1'b0;
    ra1 = 5'd5; ra2 = 5'd31;
    #1;
    total++;
    if (rd1 !== 32'd0) begin bad++; $display("FAIL reset_rd1 got=%h exp=0", rd1); end
    total++;
    if (rd2 !== 32'd0) begin bad++; $display("FAIL reset_rd2 got=%h exp=0", rd2); end
    total++;
    if (we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", we); end
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(31 - i);
      #1;
      total++;
      if (rd1 !== 32'd0 || rd2 !== 32'd0) begin
        bad++; $display("FAIL reset_all r%0d got=%h/%h exp=0", i, rd1, rd2);
      end
    end
  endtask

  task automatic test_ori_bypass();
    ra1 = 5'd8; ra2 = 5'd8;
    drive(32'h3408_1234, 32'h3004, 32'h1234, 32'd0);
    total++;
    if (we !== 1'b1 || wa !== 5'd8 || wd !== 32'h1234) begin
      bad++; $display("FAIL ori_w got=%b/%0d/%h exp=1/8/00001234", we, wa, wd);
    end
    total++;
    if (rd1 !== 32'h1234 || rd2 !== 32'h1234) begin
      bad++; $display("FAIL ori_bypass got=%h/%h exp=00001234", rd1, rd2);
    end
    cycle();
    drive(32'd0, 32'h3008, 32'd0, 32'd0);
    total++;
    if (rd1 !== 32'h1234) begin bad++; $display("FAIL ori_stored got=%h exp=00001234", rd1); end
  endtask

  task automatic test_loads();
    ra1 = 5'd9; ra2 = 5'd0;
    drive(i_ins(6'h20, 5'd0, 5'd9, 16'd0), 32'h3010, 32'h0000_0003, 32'h80FF_1122);
    total++;
    if (we !== 1'b1 || wa !== 5'd9 || wd !== 32'hFFFF_FF80) begin
      bad++; $display("FAIL lb got=%b/%0d/%h exp=1/9/ffffff80", we, wa, wd);
    end
    cycle();
    drive(i_ins(6'h24, 5'd0, 5'd9, 16'd0), 32'h3014, 32'h0000_0003, 32'h80FF_1122);
    total++;
    if (wd !== 32'h0000_0080) begin bad++; $display("FAIL lbu got=%h exp=00000080", wd); end
    cycle();
    drive(i_ins(6'h21, 5'd0, 5'd9, 16'd2), 32'h3018, 32'h0000_0002, 32'h80FF_1122);
    total++;
    if (wd !== 32'hFFFF_80FF) begin bad++; $display("FAIL lh got=%h exp=ffff80ff", wd); end
    cycle();
    drive(i_ins(6'h25, 5'd0, 5'd9, 16'd3), 32'h301c, 32'h0000_0003, 32'h80FF_1122);
    total++;
    if (wd !== 32'h0000_80FF) begin bad++; $display("FAIL lhu_misaligned got=%h exp=000080ff", wd); end
    cycle();
    drive(i_ins(6'h23, 5'd0, 5'd9, 16'd0), 32'h3020, 32'h0000_0000, 32'h80FF_1122);
    total++;
    if (wd !== 32'h80FF_1122) begin bad++; $display("FAIL lw got=%h exp=80ff1122", wd); end
    cycle();
    drive(32'd0, 32'h3024, 32'd0, 32'd0);
    total++;
    if (rd1 !== 32'h80FF_1122) begin bad++; $display("FAIL lw_stored got=%h exp=80ff1122", rd1); end
  endtask

  task automatic test_jumps();
    drive({6'h03, 26'h0000C00}, 32'h3004, 32'd0, 32'd0);
    total++;
    if (we !== 1'b1 || wa !== 5'd31 || wd !== 32'h3008) begin
      bad++; $display("FAIL jal got=%b/%0d/%h exp=1/31/00003008", we, wa, wd);
    end
    cycle();
    drive(r_ins(5'd4, 5'd0, 5'd10, 6'h09), 32'h3010, 32'd0, 32'd0);
    total++;
    if (we !== 1'b1 || wa !== 5'd10 || wd !== 32'h3014) begin
      bad++; $display("FAIL jalr got=%b/%0d/%h exp=1/10/00003014", we, wa, wd);
    end
    cycle();
    drive({6'h03, 26'h0000C00}, 32'hFFFF_FFFC, 32'd0, 32'd0);
    total++;
    if (wd !== 32'h0000_0000) begin bad++; $display("FAIL jal_wrap got=%h exp=00000000", wd); end
    cycle();
  endtask

  task automatic test_zero_reg();
    ra1 = 5'd0; ra2 = 5'd0;
    drive(r_ins(5'd1, 5'd2, 5'd0, 6'h21), 32'h3030, 32'h0000_DEAD, 32'd0);
    total++;
    if (we !== 1'b0) begin bad++; $display("FAIL addu_r0_we got=%b exp=0", we); end
    total++;
    if (rd1 !== 32'd0) begin bad++; $display("FAIL addu_r0_rd got=%h exp=0", rd1); end
    cycle();
    drive(32'd0, 32'h3034, 32'd0, 32'd0);
    total++;
    if (rd1 !== 32'd0 || rd2 !== 32'd0) begin
      bad++; $display("FAIL r0_stored got=%h/%h exp=0", rd1, rd2);
    end
  endtask

  task automatic test_no_write();
    logic [31:0] ins [4];
    ins[0] = i_ins(6'h2b, 5'd1, 5'd3, 16'd4);
    ins[1] = i_ins(6'h04, 5'd1, 5'd3, 16'd4);
    ins[2] = 32'd0;
    ins[3] = r_ins(5'd3, 5'd4, 5'd0, 6'h18);
    for (int i = 0; i < 4; i++) begin
      drive(ins[i], 32'h3040, 32'h1111_1111, 32'h2222_2222);
      total++;
      if (we !== 1'b0) begin bad++; $display("FAIL no_write[%0d] got=%b exp=0", i, we); end
      cycle();
    end
  endtask

  task automatic test_reset_priority();
    ra1 = 5'd3; ra2 = 5'd3;
    drive(i_ins(6'h0d, 5'd0, 5'd3, 16'd7), 32'h3050, 32'd7, 32'd0);
    cycle();
    drive(32'd0, 32'h3054, 32'd0, 32'd0);
    total++;
    if (rd1 !== 32'd7) begin bad++; $display("FAIL pre_reset got=%h exp=7", rd1); end
    rst = 1'b1;
    drive(i_ins(6'h0d, 5'd0, 5'd3, 16'd9), 32'h3058, 32'd9, 32'd0);
    cycle();
    rst = 1'b0;
    drive(32'd0, 32'h305c, 32'd0, 32'd0);
    total++;
    if (rd1 !== 32'd0 || rd2 !== 32'd0) begin
      bad++; $display("FAIL reset_prio got=%h/%h exp=0", rd1, rd2);
    end
  endtask

  task automatic test_random(input int n);
    logic [5:0]  ops [] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d,
                            6'h0e, 6'h0f, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h03,
                            6'h02, 6'h04, 6'h05, 6'h28, 6'h29, 6'h2b, 6'h3f};
    logic [5:0]  fns [] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21,
                            6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b,
                            6'h08, 6'h09, 6'h18, 6'h1a, 6'h3f};
    logic [31:0] s;
    logic        ewe;
    logic [4:0]  ewa;
    logic [31:0] ewd, e1, e2;
    logic [5:0]  op;
    for (int it = 0; it < n; it++) begin
      op = ops[$urandom_range(ops.size() - 1)];
      s  = $urandom;
      s[31:26] = op;
      if (op == 6'h00) s[5:0] = fns[$urandom_range(fns.size() - 1)];
      ra1 = 5'($urandom);
      ra2 = ($urandom_range(3) == 0) ? ra1 : 5'($urandom);
      if ($urandom_range(3) == 0) begin
        // Aim one read port at the current destination to exercise the bypass.
        if (op == 6'h00) ra1 = s[15:11];
        else if (op == 6'h03) ra1 = 5'd31;
        else ra1 = s[20:16];
      end
      drive(s, $urandom, $urandom, $urandom);
      ref_wb(str, pc4, alo, dmd, ewe, ewa, ewd);
      e1 = (ra1 == 5'd0) ? 32'd0 : (ewe && ewa == ra1) ? ewd : model[ra1];
      e2 = (ra2 == 5'd0) ? 32'd0 : (ewe && ewa == ra2) ? ewd : model[ra2];
      total++;
      if (we !== ewe) begin bad++; $display("FAIL rnd_we ins=%h got=%b exp=%b", s, we, ewe); end
      if (ewe) begin
        total++;
        if (wa !== ewa || wd !== ewd) begin
          bad++; $display("FAIL rnd_w ins=%h got=%0d/%h exp=%0d/%h", s, wa, wd, ewa, ewd);
        end
      end
      total++;
      if (rd1 !== e1) begin bad++; $display("FAIL rnd_rd1 ra=%0d got=%h exp=%h", ra1, rd1, e1); end
      total++;
      if (rd2 !== e2) begin bad++; $display("FAIL rnd_rd2 ra=%0d got=%h exp=%h", ra2, rd2, e2); end
      cycle();
    end
  endtask

  task automatic test_readback();
    drive(32'd0, 32'd0, 32'd0, 32'd0);
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(i);
      #1;
      total++;
      if (rd1 !== model[i] || rd2 !== model[i]) begin
        bad++; $display("FAIL readback r%0d got=%h/%h exp=%h", i, rd1, rd2, model[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    str = '0; pc4 = '0; alo = '0; dmd = '0; ra1 = '0; ra2 = '0;
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    @(negedge clk);
    test_reset();
    test_ori_bypass();
    test_loads();
    test_jumps();
    test_zero_reg();
    test_no_write();
    test_reset_priority();
    test_random(400);
    test_readback();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
